fdiv_iter: RTL and testbench

- Iterative single-precision floating-point divider, y = x1 / x2. It is the inverse-operation companion to the pipelined multiplier in the FPU.
- Restoring division, RADIX_BITS quotient bits per clock, under a start/ready/done handshake.
- Same number handling as the multiplier: denormals flush to zero, sign is XOR, exponent is biased arithmetic.
- Rounding is round-half-up on a single guard bit, with carry into the exponent.

---
 rtl/fdiv_iter.sv | 183 ++++++++++++++++++
 tb/tb_fdiv_iter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - iterative restoring single-precision divider with start/ready/done handshake
// Optional IEEE NaN/infinity handling is compiled in with macro FDIV_NAN_EN.
module fdiv_iter #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        ready,
  output logic        done,
  output logic [31:0] y
);

  localparam int N_ITER = 26 / RADIX_BITS;
  localparam int CW     = 5;

  generate
    if (RADIX_BITS != 1 && RADIX_BITS != 2) begin : g_bad_radix
      $error("fdiv_iter: RADIX_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic          sy;
  logic [7:0]    e1;
  logic [7:0]    e2;
  logic [23:0]   d;
  logic [24:0]   r;
  logic [25:0]   q;
  logic [CW-1:0] cnt;
  logic          zx;
  logic          zd;
`ifdef FDIV_NAN_EN
  logic          n1;
  logic          n2;
  logic          i1;
  logic          i2;
`endif

  logic [24:0]       r_n;
  logic [25:0]       q_n;
  logic signed [9:0] ex_b;
  logic signed [9:0] ex_r;
  logic [22:0]       mant;
  logic              g;
  logic [23:0]       mr_w;
  logic [22:0]       mr;
  logic [31:0]       y_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_n = DIV;
      end
      DIV:     if (cnt == CW'(N_ITER - 1)) state_n = ROUND;
      ROUND:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Restoring steps; each retired bit enters q at the LSB, first bit ends up at q[25].
  always_comb begin
    r_n = r;
    q_n = q;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (r_n >= {1'b0, d}) begin
        r_n = r_n - {1'b0, d};
        q_n = {q_n[24:0], 1'b1};
      end else begin
        q_n = {q_n[24:0], 1'b0};
      end
      r_n = r_n << 1;
    end
  end

  always_comb begin
    ex_b = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
    if (q[25]) begin
      mant = q[24:2];
      g    = q[1];
      ex_r = ex_b;
    end else begin
      mant = q[23:1];
      g    = q[0];
      ex_r = ex_b - 10'sd1;
    end
    mr_w = {1'b0, mant} + {23'b0, g};
    mr   = mr_w[22:0];
    if (mr_w[23]) begin
      mr   = 23'b0;
      ex_r = ex_r + 10'sd1;
    end

    if (zd)                    y_n = {sy, 8'hFF, 23'b0};
    else if (zx)               y_n = {sy, 31'b0};
    else if (ex_r <= 10'sd0)   y_n = {sy, 31'b0};
    else if (ex_r >= 10'sd255) y_n = {sy, 8'hFF, 23'b0};
    else                       y_n = {sy, ex_r[7:0], mr};

`ifdef FDIV_NAN_EN
    if (n1 || n2 || (zx && zd) || (i1 && i2)) y_n = 32'h7FC00000;
    else if (i1)                              y_n = {sy, 8'hFF, 23'b0};
    else if (i2)                              y_n = {sy, 31'b0};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sy   <= 1'b0;
      e1   <= 8'd0;
      e2   <= 8'd0;
      d    <= 24'd0;
      r    <= 25'd0;
      q    <= 26'd0;
      cnt  <= '0;
      zx   <= 1'b0;
      zd   <= 1'b0;
      done <= 1'b0;
      y    <= 32'd0;
`ifdef FDIV_NAN_EN
      n1   <= 1'b0;
      n2   <= 1'b0;
      i1   <= 1'b0;
      i2   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sy  <= x1[31] ^ x2[31];
            e1  <= x1[30:23];
            e2  <= x2[30:23];
            d   <= {1'b1, x2[22:0]};
            r   <= {2'b01, x1[22:0]};
            q   <= 26'd0;
            cnt <= '0;
            zx  <= (x1[30:23] == 8'd0);
            zd  <= (x2[30:23] == 8'd0);
`ifdef FDIV_NAN_EN
            n1  <= (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
            n2  <= (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
            i1  <= (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
            i2  <= (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);
`endif
          end
        end
        DIV: begin
          r   <= r_n;
          q   <= q_n;
          cnt <= cnt + CW'(1);
        end
        ROUND: begin
          y    <= y_n;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb/tb_fdiv_iter.sv - table-driven bench for fdiv_iter at RADIX_BITS 1 and 2
// Expected NaN results switch with FDIV_NAN_EN.
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        start1;
  logic        start2;
  logic        ready1;
  logic        ready2;
  logic        done1;
  logic        done2;
  logic [31:0] y1;
  logic [31:0] y2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fdiv_iter #(.RADIX_BITS(1)) u_r1 (
    .clk(clk), .rst(rst), .start(start1), .x1(x1), .x2(x2),
    .ready(ready1), .done(done1), .y(y1)
  );

  fdiv_iter #(.RADIX_BITS(2)) u_r2 (
    .clk(clk), .rst(rst), .start(start2), .x1(x1), .x2(x2),
    .ready(ready2), .done(done2), .y(y2)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[20];
  int   nv = 0;

  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ey);
    vecs[nv] = '{a: a, b: b, y: ey};
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 1) ? done1 : done2;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 1) ? ready1 : ready2;
  endfunction

  function automatic logic [31:0] get_y(input int sel);
    return (sel == 1) ? y1 : y2;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v;
    else          start2 = v;
  endtask

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ey, input int exp_lat, input string tag);
    int n;
    logic got;
    @(negedge clk);
    check($sformatf("%s_ready", tag), {31'b0, get_ready(sel)}, 32'd1);
    x1 = a;
    x2 = b;
    set_start(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(sel, 1'b0);
    x1 = 32'hDEADBEEF;
    x2 = 32'h12345678;
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (get_done(sel)) got = 1'b1;
    end
    check($sformatf("%s_latency", tag), n, exp_lat);
    check($sformatf("%s_y", tag), get_y(sel), ey);
  endtask

  task automatic back_to_back();
    int c;
    int c1;
    int c2;
    @(negedge clk);
    x1 = 32'h40C00000;
    x2 = 32'h40000000;
    start1 = 1'b1;
    @(posedge clk);
    c = 0;
    @(negedge clk);
    x1 = 32'h3F800000;
    x2 = 32'h40400000;
    check("b2b_busy", {31'b0, ready1}, 32'd0);
    c1 = -1;
    while (c1 < 0 && c < 100) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (done1) c1 = c;
    end
    check("b2b_first_lat", c1, 27);
    check("b2b_first_y", y1, 32'h40400000);
    check("b2b_done_ready", {31'b0, ready1}, 32'd1);
    @(posedge clk);
    c++;
    @(negedge clk);
    start1 = 1'b0;
    check("b2b_second_accepted", {31'b0, ready1}, 32'd0);
    c2 = -1;
    while (c2 < 0 && c < 200) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (done1) c2 = c;
    end
    check("b2b_gap", c2 - c1, 28);
    check("b2b_second_y", y1, 32'h3EAAAAAB);
  endtask

  task automatic reset_abort();
    int ndone;
    @(negedge clk);
    x1 = 32'h40C00000;
    x2 = 32'h40000000;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    start1 = 1'b0;
    check("abort_ready", {31'b0, ready1}, 32'd1);
    check("abort_done", {31'b0, done1}, 32'd0);
    check("abort_y", y1, 32'h00000000);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(1, 32'hBF800000, 32'h3F800000, 32'hBF800000, 27, "after_abort");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    x1     = 32'd0;
    x2     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready1", {31'b0, ready1}, 32'd1);
    check("rst_done1", {31'b0, done1}, 32'd0);
    check("rst_y1", y1, 32'd0);
    check("rst_ready2", {31'b0, ready2}, 32'd1);
    check("rst_done2", {31'b0, done2}, 32'd0);
    check("rst_y2", y2, 32'd0);
    rst = 1'b0;

    add(32'h40C00000, 32'h40000000, 32'h40400000);
    add(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    add(32'hBF800000, 32'h3F800000, 32'hBF800000);
    add(32'h3F800000, 32'hC0000000, 32'hBF000000);
    add(32'h3FC00000, 32'h3FA00000, 32'h3F99999A);
    add(32'h00000000, 32'h40000000, 32'h00000000);
    add(32'hBF800000, 32'h00000000, 32'hFF800000);
    add(32'h00800000, 32'h7F000000, 32'h00000000);
    add(32'h00800000, 32'h3F800000, 32'h00800000);
    add(32'h00800000, 32'h3FC00000, 32'h00000000);
    add(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF);
    add(32'h7F000000, 32'h3F000000, 32'h7F800000);
    add(32'h7F800000, 32'h3F800000, 32'h7F800000);
    add(32'h3F800000, 32'h7F800000, 32'h00000000);
`ifdef FDIV_NAN_EN
    add(32'h00000000, 32'h00000000, 32'h7FC00000);
    add(32'h7F800000, 32'h7F800000, 32'h7FC00000);
    add(32'h7F800001, 32'h3F800000, 32'h7FC00000);
`else
    add(32'h00000000, 32'h00000000, 32'h7F800000);
    add(32'h7F800000, 32'h7F800000, 32'h3F800000);
    add(32'h7F800001, 32'h3F800000, 32'h7F800000);
`endif

    for (int i = 0; i < nv; i++) begin
      run_op(1, vecs[i].a, vecs[i].b, vecs[i].y, 27, $sformatf("v%0d_r1", i));
      run_op(2, vecs[i].a, vecs[i].b, vecs[i].y, 14, $sformatf("v%0d_r2", i));
    end

    back_to_back();
    reset_abort();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
